// File: rtl/act_pkg.sv
// Shared definitions for the activation pipeline: mode encodings and
// counter width used by activation_pipe and act_lane.
package act_pkg;

  typedef enum logic [1:0] {
    MODE_QUAD   = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_BYPASS = 2'd2,
    MODE_LEAKY  = 2'd3
  } act_mode_e;

  localparam int SAT_COUNT_W = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/act_lane.sv
// One lane of the activation datapath: S1 bias add, S2 square,
// S3 mode select with clamp to the signed output range.
module act_lane
  import act_pkg::*;
#(
  parameter int VOLTAGE_SIZE    = 24,
  parameter int BIAS_SIZE       = 6,
  parameter int ACTIVATION_SIZE = 54
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              advance,
  input  logic signed [VOLTAGE_SIZE-2:0]    x,
  input  logic signed [BIAS_SIZE-1:0]       bias,
  input  act_mode_e                         mode,
  output logic signed [ACTIVATION_SIZE-1:0] act,
  output logic                              sat
);

  localparam int XW = VOLTAGE_SIZE - 1;
  localparam int SW = VOLTAGE_SIZE + 1;
  localparam int PW = 2 * SW;
  localparam int MW = max_int(PW + 1, ACTIVATION_SIZE) + 1;

  localparam logic signed [MW-1:0] ACT_MAX =
    {{(MW - ACTIVATION_SIZE + 1){1'b0}}, {(ACTIVATION_SIZE - 1){1'b1}}};
  localparam logic signed [MW-1:0] ACT_MIN = ~ACT_MAX;
  localparam logic signed [SW-1:0] S_ZERO  = '0;
  localparam logic signed [SW-1:0] S_NEG2  = {{(SW - 2){1'b1}}, 2'b10};

  logic signed [SW-1:0] x_ext;
  logic signed [SW-1:0] bias_ext;
  logic signed [SW-1:0] s1;
  act_mode_e            mode1;

  logic signed [PW-1:0] s1_wide;
  logic signed [SW-1:0] s2;
  logic signed [PW-1:0] p2;
  act_mode_e            mode2;

  logic signed [MW-1:0] s_m;
  logic signed [MW-1:0] p_m;
  logic signed [MW-1:0] res;
  logic signed [ACTIVATION_SIZE-1:0] act_n;
  logic                 sat_n;

  assign x_ext    = {{(SW - XW){x[XW-1]}}, x};
  assign bias_ext = {{(SW - BIAS_SIZE){bias[BIAS_SIZE-1]}}, bias};
  assign s1_wide  = {{SW{s1[SW-1]}}, s1};

  assign s_m = {{(MW - SW){s2[SW-1]}}, s2};
  assign p_m = {{(MW - PW){p2[PW-1]}}, p2};

  // Result is formed at a width that holds every mode exactly, then clamped.
  always_comb begin
    res   = '0;
    act_n = '0;
    sat_n = 1'b0;
    case (mode2)
      MODE_QUAD: begin
        if (s2 > S_ZERO)       res = s_m + p_m;
        else if (s2 >= S_NEG2) res = s_m + (p_m <<< 4);
        else                   res = '0;
      end
      MODE_RELU:   res = (s2 > S_ZERO) ? s_m : '0;
      MODE_BYPASS: res = s_m;
      MODE_LEAKY:  res = (s2 > S_ZERO) ? s_m : (s_m >>> 3);
      default:     res = '0;
    endcase
    if (res > ACT_MAX) begin
      act_n = ACT_MAX[ACTIVATION_SIZE-1:0];
      sat_n = 1'b1;
    end else if (res < ACT_MIN) begin
      act_n = ACT_MIN[ACTIVATION_SIZE-1:0];
      sat_n = 1'b1;
    end else begin
      act_n = res[ACTIVATION_SIZE-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      mode1 <= MODE_QUAD;
      s2    <= '0;
      p2    <= '0;
      mode2 <= MODE_QUAD;
      act   <= '0;
      sat   <= 1'b0;
    end else if (advance) begin
      s1    <= x_ext + bias_ext;
      mode1 <= mode;
      s2    <= s1;
      p2    <= s1_wide * s1_wide;
      mode2 <= mode1;
      act   <= act_n;
      sat   <= sat_n;
    end
  end

endmodule

// File: rtl/activation_pipe.sv
// Multi-lane activation pipeline: valid/ready handshake, bias and mode
// configuration, and a sticky count of beats that saturated.
module activation_pipe
  import act_pkg::*;
#(
  parameter int VOLTAGE_SIZE    = 24,
  parameter int BIAS_SIZE       = 6,
  parameter int ACTIVATION_SIZE = 54,
  parameter int CHANNELS        = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [CHANNELS*(VOLTAGE_SIZE-1)-1:0]   in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [CHANNELS*ACTIVATION_SIZE-1:0]    out_data,
  input  logic                                   cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [BIAS_SIZE-1:0]                   cfg_bias,
  input  logic                                   cfg_mode_we,
  input  logic [1:0]                             cfg_mode,
  output logic [SAT_COUNT_W-1:0]                 sat_count
);

  localparam int XW  = VOLTAGE_SIZE - 1;
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                        advance;
  logic                        v1, v2, v3;
  logic signed [BIAS_SIZE-1:0] bias_r [CHANNELS];
  act_mode_e                   mode_r;
  logic [CHANNELS-1:0]         sat_vec;
  logic signed [ACTIVATION_SIZE-1:0] lane_act [CHANNELS];

  assign advance   = out_ready || !out_valid;
  assign in_ready  = advance;
  assign out_valid = v3;

  // Stage valids move in lockstep with the lane data so bubbles stay in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (advance) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) bias_r[i] <= '0;
      mode_r <= MODE_QUAD;
    end else begin
      if (cfg_we) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (cfg_ch == CHW'(i)) bias_r[i] <= cfg_bias;
        end
      end
      if (cfg_mode_we) mode_r <= act_mode_e'(cfg_mode);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && (|sat_vec) && (sat_count != '1)) begin
      sat_count <= sat_count + SAT_COUNT_W'(1);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    act_lane #(
      .VOLTAGE_SIZE   (VOLTAGE_SIZE),
      .BIAS_SIZE      (BIAS_SIZE),
      .ACTIVATION_SIZE(ACTIVATION_SIZE)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .advance(advance),
      .x      (in_data[c*XW +: XW]),
      .bias   (bias_r[c]),
      .mode   (mode_r),
      .act    (lane_act[c]),
      .sat    (sat_vec[c])
    );
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      out_data[i*ACTIVATION_SIZE +: ACTIVATION_SIZE] = lane_act[i];
    end
  end

endmodule

// File: tb/tb_activation_pipe.sv
// Directed self-checking bench for activation_pipe with 32-bit outputs
// so the saturation path is reachable.
module tb_activation_pipe;

  localparam int VS = 24;
  localparam int BS = 6;
  localparam int AS = 32;
  localparam int CH = 4;
  localparam int XW = VS - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [CH*XW-1:0]   in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [CH*AS-1:0]   out_data;
  logic               cfg_we = 1'b0;
  logic [1:0]         cfg_ch = '0;
  logic [BS-1:0]      cfg_bias = '0;
  logic               cfg_mode_we = 1'b0;
  logic [1:0]         cfg_mode = '0;
  logic [15:0]        sat_count;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  activation_pipe #(
    .VOLTAGE_SIZE   (VS),
    .BIAS_SIZE      (BS),
    .ACTIVATION_SIZE(AS),
    .CHANNELS       (CH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_bias   (cfg_bias),
    .cfg_mode_we(cfg_mode_we),
    .cfg_mode   (cfg_mode),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkLanes(input string tag, input int e0, input int e1,
                            input int e2, input int e3);
    int exp_v [4];
    logic [31:0] e;
    exp_v = '{e0, e1, e2, e3};
    for (int l = 0; l < CH; l++) begin
      e = exp_v[l];
      checkOutput($sformatf("%s_lane%0d", tag, l), {32'b0, out_data[l*AS +: AS]}, {32'b0, e});
    end
  endtask

  function automatic logic [CH*XW-1:0] pack(input int a, input int b, input int c, input int d);
    logic [XW-1:0] la, lb, lc, ld;
    la = XW'(a);
    lb = XW'(b);
    lc = XW'(c);
    ld = XW'(d);
    return {ld, lc, lb, la};
  endfunction

  task automatic applyStimulus(input logic [CH*XW-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic writeBias(input int ch, input int b);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_bias = BS'(b);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic writeMode(input int m);
    cfg_mode_we = 1'b1;
    cfg_mode    = 2'(m);
    tick();
    cfg_mode_we = 1'b0;
  endtask

  task automatic waitOutput(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    tick();
    tick();
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data_lo", out_data[63:0], 64'd0);
    checkOutput("rst_sat_count", 64'(sat_count), 64'd0);
    reset = 1'b0;
    tick();
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    // Quadratic 5+3 -> 72, with exact 3-cycle latency
    writeBias(0, 3);
    applyStimulus(pack(5, 0, 0, 0));
    checkOutput("lat_c1", 64'(out_valid), 64'd0);
    tick();
    checkOutput("lat_c2", 64'(out_valid), 64'd0);
    tick();
    checkOutput("lat_c3", 64'(out_valid), 64'd1);
    checkLanes("quad72", 72, 0, 0, 0);

    // Quadratic region boundaries; bias+mode change right behind an in-flight beat
    writeBias(0, -1);
    applyStimulus(pack(-1, -3, 0, 2));
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_bias = '0;
    cfg_mode_we = 1'b1; cfg_mode = 2'd1;
    tick();
    cfg_we = 1'b0; cfg_mode_we = 1'b0;
    waitOutput("quad_edge");
    checkLanes("quad_edge", 62, 0, 0, 6);

    applyStimulus(pack(9, -7, 100, -1));
    waitOutput("relu");
    checkLanes("relu", 9, 0, 100, 0);

    writeMode(3);
    applyStimulus(pack(-16, 7, -1, -8));
    waitOutput("leaky");
    checkLanes("leaky", -2, 7, -1, -1);

    writeMode(2);
    applyStimulus(pack(-5, 1000, -4194304, 4194303));
    waitOutput("bypass");
    checkLanes("bypass", -5, 1000, -4194304, 4194303);

    writeMode(1);
    applyStimulus(pack(-16, 3, 0, -2));
    waitOutput("relu_next");
    checkLanes("relu_next", 0, 3, 0, 0);

    // Back-pressure in bypass: three beats fill the pipe, the fourth waits
    writeMode(2);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pack(11, 111, 0, 0);
    tick();
    in_data   = pack(12, 112, 0, 0);
    tick();
    in_data   = pack(13, 113, 0, 0);
    tick();
    in_data   = pack(14, 114, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
      checkOutput($sformatf("bp_valid_%0d", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("bp_hold_%0d", i), out_data[63:0], {32'd111, 32'd11});
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checkLanes("bp_b1", 12, 112, 0, 0);
    tick();
    checkLanes("bp_b2", 13, 113, 0, 0);
    tick();
    checkOutput("bp_b3_valid", 64'(out_valid), 64'd1);
    checkLanes("bp_b3", 14, 114, 0, 0);
    tick();
    checkOutput("bp_drained", 64'(out_valid), 64'd0);

    // Saturation and sticky counter
    writeMode(0);
    writeBias(0, 31);
    applyStimulus(pack(4194303, 0, 0, 0));
    waitOutput("sat");
    checkLanes("sat", 32'h7FFF_FFFF, 0, 0, 0);
    tick();
    checkOutput("sat_count_1", 64'(sat_count), 64'd1);
    in_data  = pack(4194303, 0, 0, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 65533; i++) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    checkOutput("sat_count_fffe", 64'(sat_count), 64'hFFFE);
    in_valid = 1'b1;
    for (int i = 0; i < 4466; i++) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    checkOutput("sat_count_sticky", 64'(sat_count), 64'hFFFF);

    // Reset with a full stalled pipe, colliding with a bias write and an accept
    writeMode(1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pack(1, 1, 1, 1);
    tick();
    tick();
    tick();
    checkOutput("pre_rst_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_bias = 6'd7;
    in_data = pack(5, -1, 0, 0);
    tick();
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_sat", 64'(sat_count), 64'd0);
    checkOutput("mid_rst_data_lo", out_data[63:0], 64'd0);
    checkOutput("mid_rst_data_hi", out_data[127:64], 64'd0);
    reset = 1'b0;
    cfg_we = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("post_rst_quiet_%0d", i), 64'(out_valid), 64'd0);
    end
    applyStimulus(pack(5, -1, 0, 0));
    waitOutput("post_rst");
    checkLanes("post_rst", 30, 15, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/activation_pipe.md
ACTIVATION_PIPE -- requirements
Module: activation_pipe

Interface
REQ-001 SHALL have parameter VOLTAGE_SIZE, default 24, the sum width plus one; each input sample is VOLTAGE_SIZE-1 bits signed.
REQ-002 SHALL have parameter BIAS_SIZE, default 6, the signed per-channel bias width.
REQ-003 SHALL have parameter ACTIVATION_SIZE, default 54, the signed output sample width.
REQ-004 SHALL have parameter CHANNELS, default 4, the number of lanes processed per beat.
REQ-005 clk  in  1  single clock, all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
REQ-009 in_data  in  CHANNELS*(VOLTAGE_SIZE-1)  packed signed sums, with channel 0 in the LSBs.
REQ-010 out_valid  out  1  output beat valid.
REQ-011 out_ready  in  1  downstream accepts the output beat.
REQ-012 out_data  out  CHANNELS*ACTIVATION_SIZE  packed signed activations, with channel 0 in the LSBs.
REQ-013 cfg_we  in  1  configuration write strobe.
REQ-014 cfg_ch  in  clog2(CHANNELS) bits (minimum 1)  target channel of the bias write.
REQ-015 cfg_bias  in  BIAS_SIZE  bias value written to bias[cfg_ch].
REQ-016 cfg_mode_we  in  1  mode write strobe.
REQ-017 cfg_mode  in  2  activation mode, shared by all channels.
REQ-018 sat_count  out  16  count of output beats in which at least one lane saturated.

Function
REQ-019 Pipeline SHALL have 3 register stages: S1 bias add, S2 square, S3 select and saturate; latency from input accept to out_valid SHALL be 3 cycles when there is no stall.
REQ-020 Advance SHALL be (out_ready or not out_valid); all stages move together on advance and hold otherwise; in_ready SHALL equal advance.
REQ-021 Per lane, S1 SHALL compute s = x + bias[ch], sign-extended to VOLTAGE_SIZE+1 bits, with no overflow possible.
REQ-022 S2 SHALL register s and p = s*s at full 2*(VOLTAGE_SIZE+1)-bit width.
REQ-023 Mode 0 (quadratic): s>0 -> s+p; -2<=s<=0 -> s+(p<<4); s<-2 -> 0.
REQ-024 Mode 1 (ReLU): s>0 -> s; otherwise 0.
REQ-025 Mode 2 (bypass): s, sign-extended.
REQ-026 Mode 3 (leaky): s>0 -> s; otherwise s>>>3, arithmetic shift.
REQ-027 S3 SHALL clamp each lane's result to the signed ACTIVATION_SIZE range.
REQ-028 sat_count SHALL increment by 1 per accepted output beat with any clamped lane, and SHALL stick at 0xFFFF.
REQ-029 Bias and mode values SHALL be sampled when a beat enters S1.
REQ-030 A cfg write in cycle N SHALL affect beats accepted in cycle N+1 or later.
REQ-031 A bias write SHALL never alter beats already in flight.
REQ-032 Simultaneous cfg_we and cfg_mode_we SHALL both take effect.
REQ-033 A cfg write during a stall SHALL take effect, and SHALL NOT affect held stages.
REQ-034 Bubbles SHALL propagate as invalid stages and are not collapsed; out_valid SHALL be the S3 valid bit.
REQ-035 Beats SHALL never be dropped or duplicated.
REQ-036 Beats SHALL leave in acceptance order.
REQ-037 out_data SHALL be stable while out_valid is high and out_ready is low.

Reset
REQ-038 On reset, all stage valid bits SHALL clear, so out_valid=0 the following cycle.
REQ-039 On reset, out_data SHALL be 0, sat_count 0, every bias 0, and mode 0.
REQ-040 in_ready SHALL be 1 after reset.
REQ-041 Reset mid-stream SHALL discard all in-flight beats without emitting them.
REQ-042 Reset SHALL take priority over cfg writes and accepts in the same cycle.

Structure
REQ-043 Shared package act_pkg SHALL hold the mode encodings (MODE_QUAD, MODE_RELU, MODE_BYPASS, MODE_LEAKY) and the SAT_COUNT_W=16 constant.
REQ-044 Per-lane S1-S3 datapath SHALL be sub-module act_lane, instantiated CHANNELS times.
REQ-045 Handshake, configuration registers and sat_count SHALL live in activation_pipe.

Verification
REQ-046 Mode 0, bias[0]=3, x=5 -> out lane0=72, with out_valid exactly 3 cycles after accept.
REQ-047 Mode 0: bias -1, x=-1 -> s=-2 -> 62; bias 0, x=-3 -> 0; bias 0, x=0 -> 0.
REQ-048 Mode 1: x=-7 -> 0, x=9 -> 9; mode 3: x=-16 -> -2; write mode 1 then issue a beat the next cycle -> ReLU result applies.
REQ-049 Back-pressure: send 4 back-to-back beats, hold out_ready low 5 cycles -> in_ready low, out_data stable, then all 4 beats emitted in order.
REQ-050 ACTIVATION_SIZE=32, mode 0, x=2^22-1, bias 31 -> lane=2^31-1 and sat_count=1; send 70000 such beats -> sat_count=0xFFFF.
REQ-051 Assert reset with 3 beats in flight -> out_valid=0 next cycle, no flushed beat emitted, sat_count=0, biases read back as 0.
